// File: rtl/lab2_proc_mem_port_arbiter_pkg.sv
// Shared definitions for the processor memory-port arbiter: requester ids
// and the 4B memory request/response message layouts.
package lab2_proc_mem_port_arbiter_pkg;

    localparam logic ARB_PORT_DMEM = 1'b0;
    localparam logic ARB_PORT_IMEM = 1'b1;

    localparam int unsigned MEM_REQ_4B_W  = 77;
    localparam int unsigned MEM_RESP_4B_W = 47;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4b_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4b_t;

endpackage

// File: rtl/lab2_proc_mem_port_arbiter_chk.sv
// Protocol checks for the arbiter: no memory response without an
// outstanding request, and never two requesters accepted at once.
module lab2_proc_mem_port_arbiter_chk
(
    input logic clk,
    input logic reset,
    input logic mem_resp_val,
    input logic fifo_empty,
    input logic req0_rdy,
    input logic req1_rdy
);

    resp_needs_tag_a: assert property (@(posedge clk) disable iff (reset)
        !(mem_resp_val && fifo_empty));

    single_accept_a: assert property (@(posedge clk) disable iff (reset)
        !(req0_rdy && req1_rdy));

endmodule

// File: rtl/lab2_proc_mem_port_arbiter_tagq.sv
// In-order FIFO of requester ids for requests issued to memory but not yet
// answered; the head tells the response path where to steer.
module lab2_proc_mem_port_arbiter_tagq
    import lab2_proc_mem_port_arbiter_pkg::*;
#(
    parameter int unsigned p_depth = 4
)
(
    input  logic clk,
    input  logic reset,
    input  logic enq_val_i,
    input  logic enq_id_i,
    input  logic deq_val_i,
    output logic full_o,
    output logic empty_o,
    output logic head_id_o
);

    localparam int unsigned PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned CNT_W = $clog2(p_depth + 1);

    logic [p_depth-1:0] ids_q, ids_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               enq_fire_s;
    logic               deq_fire_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(p_depth - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    assign full_o     = (cnt_q == CNT_W'(p_depth));
    assign empty_o    = (cnt_q == {CNT_W{1'b0}});
    assign head_id_o  = ids_q[rd_ptr_q];
    // A full queue never accepts, even when a pop happens in the same cycle.
    assign enq_fire_s = enq_val_i & ~full_o;
    assign deq_fire_s = deq_val_i & ~empty_o;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (enq_fire_s) begin
            ids_d[wr_ptr_q] = enq_id_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (deq_fire_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({enq_fire_s, deq_fire_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ids_q    <= {p_depth{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            ids_q    <= ids_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/lab2_proc_mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between dmem (port 0) and
// imem (port 1); responses are steered back using an in-order id FIFO.
module lab2_proc_mem_port_arbiter
    import lab2_proc_mem_port_arbiter_pkg::*;
#(
    parameter int unsigned p_max_inflight = 4
)
(
    input  logic         clk,
    input  logic         reset,

    input  mem_req_4b_t  req0_msg,
    input  logic         req0_val,
    output logic         req0_rdy,
    input  mem_req_4b_t  req1_msg,
    input  logic         req1_val,
    output logic         req1_rdy,

    output mem_req_4b_t  mem_req_msg,
    output logic         mem_req_val,
    input  logic         mem_req_rdy,
    input  mem_resp_4b_t mem_resp_msg,
    input  logic         mem_resp_val,
    output logic         mem_resp_rdy,

    output mem_resp_4b_t resp0_msg,
    output logic         resp0_val,
    input  logic         resp0_rdy,
    output mem_resp_4b_t resp1_msg,
    output logic         resp1_val,
    input  logic         resp1_rdy
);

    logic rr_ptr_q, rr_ptr_d;
    logic grant_s;
    logic any_val_s;
    logic act_s;
    logic can_issue_s;
    logic req_fire_s;
    logic resp_fire_s;
    logic head_rdy_s;
    logic fifo_full_s;
    logic fifo_empty_s;
    logic head_id_s;

    assign act_s       = ~reset;
    assign any_val_s   = req0_val | req1_val;
    assign can_issue_s = act_s & ~fifo_full_s;

    // Grant selection: priority port on contention, otherwise the lone requester.
    always_comb begin
        grant_s = ARB_PORT_DMEM;
        if (req0_val && req1_val) begin
            grant_s = rr_ptr_q;
        end else if (req1_val) begin
            grant_s = ARB_PORT_IMEM;
        end else begin
            grant_s = ARB_PORT_DMEM;
        end
    end

    assign mem_req_msg = (grant_s == ARB_PORT_IMEM) ? req1_msg : req0_msg;
    assign mem_req_val = any_val_s & can_issue_s;
    assign req0_rdy    = (grant_s == ARB_PORT_DMEM) & can_issue_s & mem_req_rdy;
    assign req1_rdy    = (grant_s == ARB_PORT_IMEM) & can_issue_s & mem_req_rdy;
    assign req_fire_s  = mem_req_val & mem_req_rdy;

    // The port that just won yields priority to the other one.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (req_fire_s) begin
            rr_ptr_d = ~grant_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin priority register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= ARB_PORT_DMEM;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign head_rdy_s   = (head_id_s == ARB_PORT_IMEM) ? resp1_rdy : resp0_rdy;
    assign mem_resp_rdy = act_s & ~fifo_empty_s & head_rdy_s;
    assign resp_fire_s  = mem_resp_val & mem_resp_rdy;

    assign resp0_msg = mem_resp_msg;
    assign resp1_msg = mem_resp_msg;
    assign resp0_val = act_s & mem_resp_val & ~fifo_empty_s & (head_id_s == ARB_PORT_DMEM);
    assign resp1_val = act_s & mem_resp_val & ~fifo_empty_s & (head_id_s == ARB_PORT_IMEM);

    lab2_proc_mem_port_arbiter_tagq #(
        .p_depth   (p_max_inflight)
    ) u_tagq (
        .clk       (clk),
        .reset     (reset),
        .enq_val_i (req_fire_s),
        .enq_id_i  (grant_s),
        .deq_val_i (resp_fire_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .head_id_o (head_id_s)
    );

    lab2_proc_mem_port_arbiter_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .mem_resp_val (mem_resp_val),
        .fifo_empty   (fifo_empty_s),
        .req0_rdy     (req0_rdy),
        .req1_rdy     (req1_rdy)
    );

endmodule

// File: tb/tb_lab2_proc_mem_port_arbiter.sv
// Bench for the memory-port arbiter: requester generators, a latency-2
// memory model and per-port in-order response scoreboards.
module tb_lab2_proc_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [76:0] req0_msg, req1_msg, mem_req_msg;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic        mem_req_val, mem_req_rdy;
    logic [46:0] mem_resp_msg, resp0_msg, resp1_msg;
    logic        mem_resp_val, mem_resp_rdy;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;

    always #5 clk = ~clk;

    lab2_proc_mem_port_arbiter #(.p_max_inflight(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_msg     (req0_msg),
        .req0_val     (req0_val),
        .req0_rdy     (req0_rdy),
        .req1_msg     (req1_msg),
        .req1_val     (req1_val),
        .req1_rdy     (req1_rdy),
        .mem_req_msg  (mem_req_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_resp_msg (mem_resp_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy),
        .resp0_msg    (resp0_msg),
        .resp0_val    (resp0_val),
        .resp0_rdy    (resp0_rdy),
        .resp1_msg    (resp1_msg),
        .resp1_val    (resp1_val),
        .resp1_rdy    (resp1_rdy)
    );

    int checks = 0;
    int failures = 0;

    // Generator, memory and scoreboard state
    logic        pend [2];
    logic [76:0] gmsg [2];
    int          gcnt [2];
    int          glim [2];
    int          pv [2];
    int          prr [2];
    int          pmr, pmv;
    int          cyc = 0;
    int          nresp [2];
    logic [76:0] mq [$];
    int          mq_t [$];
    logic [46:0] expq0 [$];
    logic [46:0] expq1 [$];
    int          grants [$];

    // Observations from the most recent cycle
    logic [5:0]  o_zero;
    logic        o_req0_rdy, o_req1_rdy, o_mem_req_val, o_mem_resp_rdy;
    logic        o_resp0_val, o_resp1_val;
    logic [46:0] o_resp0_msg;
    logic [31:0] o_addr;
    logic        f_mfire, f_mrf;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [46:0] resp_of(input logic [76:0] r);
        return {r[76:74], r[73:66], 2'b00, r[33:32], r[31:0] ^ r[65:34]};
    endfunction

    function automatic logic [76:0] mk(input int p, input int n);
        logic [31:0] addr;
        addr = ((p == 1) ? 32'h200 : 32'h100) + 32'(n * 4);
        return {3'(n % 2), 1'(p), 7'(n), addr, 2'b00, 32'($urandom())};
    endfunction

    function automatic logic roll(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic setup(input int l0, input int l1, input int v0, input int v1,
                         input int mr, input int mv, input int r0, input int r1);
        glim[0] = l0; glim[1] = l1; gcnt[0] = 0; gcnt[1] = 0;
        pv[0] = v0; pv[1] = v1; pmr = mr; pmv = mv; prr[0] = r0; prr[1] = r1;
        nresp[0] = 0; nresp[1] = 0;
        grants.delete();
    endtask

    // One clock: drive at posedge+1, sample/score at negedge
    task automatic cycle();
        logic f0, f1, r0f, r1f;
        for (int p = 0; p < 2; p++) begin
            if (!pend[p] && gcnt[p] < glim[p] && roll(pv[p])) begin
                gmsg[p] = mk(p, gcnt[p]);
                pend[p] = 1'b1;
                gcnt[p]++;
            end
        end
        req0_val = pend[0]; req0_msg = gmsg[0];
        req1_val = pend[1]; req1_msg = gmsg[1];
        mem_req_rdy  = roll(pmr);
        mem_resp_val = (mq.size() > 0) && (mq_t[0] <= cyc) && roll(pmv);
        mem_resp_msg = (mq.size() > 0) ? resp_of(mq[0]) : 47'd0;
        resp0_rdy = roll(prr[0]);
        resp1_rdy = roll(prr[1]);
        #4;
        o_zero = {mem_req_val, req0_rdy, req1_rdy, mem_resp_rdy, resp0_val, resp1_val};
        o_req0_rdy = req0_rdy; o_req1_rdy = req1_rdy; o_mem_req_val = mem_req_val;
        o_mem_resp_rdy = mem_resp_rdy; o_resp0_val = resp0_val; o_resp1_val = resp1_val;
        o_resp0_msg = resp0_msg; o_addr = mem_req_msg[65:34];
        f0 = req0_val & req0_rdy;
        f1 = req1_val & req1_rdy;
        f_mfire = mem_req_val & mem_req_rdy;
        r0f = resp0_val & resp0_rdy;
        r1f = resp1_val & resp1_rdy;
        f_mrf = mem_resp_val & mem_resp_rdy;
        if (!reset) begin
            if (f_mfire) begin
                chk_eq("req_fire_one", 2'(f0) + 2'(f1), 2'd1);
                if (f1) begin
                    chk_eq("mem_req_msg1", mem_req_msg, gmsg[1]);
                    expq1.push_back(resp_of(gmsg[1]));
                    pend[1] = 1'b0;
                    grants.push_back(1);
                end else begin
                    chk_eq("mem_req_msg0", mem_req_msg, gmsg[0]);
                    expq0.push_back(resp_of(gmsg[0]));
                    pend[0] = 1'b0;
                    grants.push_back(0);
                end
                mq.push_back(mem_req_msg);
                mq_t.push_back(cyc + 2);
            end else if (f0 | f1) begin
                chk_eq("req_fire_without_mem", 1'b1, 1'b0);
            end
            if (r0f | r1f | f_mrf) begin
                chk_eq("resp_route", 2'(r0f) + 2'(r1f), f_mrf ? 2'd1 : 2'd0);
            end
            if (resp0_val & resp1_val) begin
                chk_eq("both_resp_val", 1'b1, 1'b0);
            end
            if (r0f) begin
                if (expq0.size() == 0) chk_eq("resp0_unexpected", 1'b1, 1'b0);
                else chk_eq("resp0_msg", resp0_msg, expq0.pop_front());
                nresp[0]++;
            end
            if (r1f) begin
                if (expq1.size() == 0) chk_eq("resp1_unexpected", 1'b1, 1'b0);
                else chk_eq("resp1_msg", resp1_msg, expq1.pop_front());
                nresp[1]++;
            end
            if (f_mrf && mq.size() > 0) begin
                void'(mq.pop_front());
                void'(mq_t.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rst(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        mq.delete(); mq_t.delete(); expq0.delete(); expq1.delete();
        pend[0] = 1'b0; pend[1] = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        logic seen0;
        bit   done;
        reset = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        gmsg[0] = '0; gmsg[1] = '0;
        setup(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst(2);

        // Lone imem request: accepted same cycle, answered on port 1 only
        setup(0, 1, 0, 100, 100, 100, 100, 100);
        cycle();
        chk_eq("t1_req1_rdy", o_req1_rdy, 1'b1);
        chk_eq("t1_addr", o_addr, 32'h200);
        seen0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            seen0 |= o_resp0_val;
        end
        chk_eq("t1_resp1_cnt", nresp[1], 1);
        chk_eq("t1_no_resp0", seen0, 1'b0);

        // Both always valid: alternating grants starting at port 0
        rst(1);
        setup(4, 4, 100, 100, 100, 100, 100, 100);
        for (int i = 0; i < 14; i++) cycle();
        chk_eq("t2_nfire", grants.size(), 8);
        for (int i = 0; i < grants.size(); i++) begin
            chk_eq($sformatf("t2_grant%0d", i), grants[i], i % 2);
        end
        chk_eq("t2_resp0_cnt", nresp[0], 4);
        chk_eq("t2_resp1_cnt", nresp[1], 4);

        // Full: 4 grants then stall; pop does not bypass, grant resumes next cycle
        rst(1);
        setup(100, 100, 100, 100, 100, 0, 100, 100);
        for (int i = 0; i < 6; i++) cycle();
        chk_eq("t3_nfire", grants.size(), 4);
        chk_eq("t3_rdy_blocked", o_req0_rdy | o_req1_rdy, 1'b0);
        chk_eq("t3_mem_val_blocked", o_mem_req_val, 1'b0);
        pmv = 100;
        cycle();
        chk_eq("t3_pop", f_mrf, 1'b1);
        chk_eq("t3_no_bypass", f_mfire, 1'b0);
        pmv = 0;
        cycle();
        chk_eq("t3_resume", f_mfire, 1'b1);

        // Head response for port 0 held while dmem not ready
        rst(1);
        setup(1, 1, 100, 100, 100, 100, 0, 100);
        cycle();
        cycle();
        chk_eq("t4_exp0", expq0.size(), 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk_eq("t4_mem_resp_rdy", o_mem_resp_rdy, 1'b0);
            chk_eq("t4_resp0_val", o_resp0_val, 1'b1);
            chk_eq("t4_resp1_val", o_resp1_val, 1'b0);
            chk_eq("t4_resp0_msg", o_resp0_msg, expq0[0]);
        end
        prr[0] = 100;
        for (int i = 0; i < 5; i++) cycle();
        chk_eq("t4_resp0_cnt", nresp[0], 1);
        chk_eq("t4_resp1_cnt", nresp[1], 1);

        // Reset with 3 in flight: outputs gated, count and priority cleared
        rst(1);
        setup(100, 100, 100, 100, 100, 0, 100, 100);
        for (int i = 0; i < 3; i++) cycle();
        chk_eq("t5_inflight", grants.size(), 3);
        pmv = 100;
        rst(1);
        chk_eq("t5_reset_outputs", o_zero, 6'd0);
        setup(100, 100, 100, 100, 100, 0, 100, 100);
        for (int i = 0; i < 6; i++) cycle();
        chk_eq("t5_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);
        chk_eq("t5_nfire_after_reset", grants.size(), 4);

        // Random traffic on all streams, 500 requests per port
        rst(1);
        setup(500, 500, 70, 60, 70, 60, 70, 60);
        done = 1'b0;
        for (int i = 0; i < 30000 && !done; i++) begin
            cycle();
            done = (nresp[0] == 500) && (nresp[1] == 500);
        end
        chk_eq("t6_done", done, 1'b1);
        chk_eq("t6_resp0_cnt", nresp[0], 500);
        chk_eq("t6_resp1_cnt", nresp[1], 500);
        chk_eq("t6_leftover", expq0.size() + expq1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
